// File: rtl/div_unsigned_64_if.sv
// Operand/result handshake bundle for the iterative unsigned divider.
// The master side is the producer of operands and the consumer of results.
interface div_unsigned_64_if #(
  parameter int XLEN = 64
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;
  logic            div_by_zero;

  modport master (
    output flush, in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  flush, in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_unsigned_64.sv
// Iterative restoring divider on operand magnitudes: one quotient bit per clock,
// 64 iterations per result, zero divisor short-circuits to a flagged result.
module div_unsigned_64 #(
  parameter int XLEN = 64
) (
  input  logic                clk,
  input  logic                rst,
  div_unsigned_64_if.slave    bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [5:0]      cnt_q,   cnt_d;
  logic [XLEN-1:0] quo_q,   quo_d;
  logic [XLEN-1:0] rem_q,   rem_d;
  logic [XLEN-1:0] dvs_q,   dvs_d;
  logic            dbz_q,   dbz_d;

  // The 65-bit partial remainder always ends an iteration below the divisor, so
  // its top bit is zero between edges; only the shifted and trial values need it.
  logic [XLEN:0]   r_shift;
  logic [XLEN:0]   r_trial;

  assign r_shift = {rem_q, quo_q[XLEN-1]};
  assign r_trial = r_shift - {1'b0, dvs_q};

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    dbz_d   = dbz_q;

    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            dvs_d = bus.divisor;
            cnt_d = 6'd63;
            if (bus.divisor == '0) begin
              quo_d   = '1;
              rem_d   = bus.dividend;
              dbz_d   = 1'b1;
              state_d = DONE;
            end else begin
              quo_d   = bus.dividend;
              rem_d   = '0;
              dbz_d   = 1'b0;
              state_d = BUSY;
            end
          end
        end
        BUSY: begin
          if (!r_trial[XLEN]) begin
            rem_d = r_trial[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = r_shift[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd0) state_d = DONE;
        end
        DONE: begin
          if (bus.out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_unsigned_64.sv
// Self-checking bench for div_unsigned_64: directed vector table, handshake corner
// sequences (backpressure, flush, async reset) and random operands vs. / and %.
module tb_div_unsigned_64;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  div_unsigned_64_if bus ();

  div_unsigned_64 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] q;
    logic [63:0] r;
    logic        dbz;
    int          stall;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour straight from arithmetic definitions.
  task automatic model(input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] q, output logic [63:0] r, output logic d);
    if (b == 64'd0) begin
      q = '1;
      r = a;
      d = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      d = 1'b0;
    end
  endtask

  // Accept one operation, measure latency, optionally stall the result, then hand off.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] eq, input logic [63:0] er, input logic ed,
                        input int stall);
    int w;
    int lat;
    w = 0;
    while (!bus.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.out_ready = (stall == 0);
    bus.in_valid  = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.dividend  = {$urandom, $urandom};
    bus.divisor   = {$urandom, $urandom};
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), (b == 64'd0) ? 64'd0 : 64'd64);
    check({tag, "_quotient"}, bus.quotient, eq);
    check({tag, "_remainder"}, bus.remainder, er);
    check({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(ed));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
      check({tag, "_hold_quotient"}, bus.quotient, eq);
      check({tag, "_hold_remainder"}, bus.remainder, er);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_ready_again"}, 64'(bus.in_ready), 64'd1);
  endtask

  // Start a nonzero-divisor op and leave it running for `cycles` negedges inside BUSY.
  task automatic start_and_run(input int cycles);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.dividend  = 64'd100;
    bus.divisor   = 64'd7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    check("kill_busy", 64'(bus.in_ready), 64'd0);
  endtask

  task automatic expect_no_valid(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  vec_t vecs[8];

  initial begin
    logic [63:0] a, b, eq, er;
    logic        ed;
    n_cmp  = 0;
    n_fail = 0;
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;

    vecs[0] = '{64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 0};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd1,
                64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 0};
    vecs[3] = '{64'd12345, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd12345, 1'b1, 0};
    vecs[4] = '{64'd5, 64'd9, 64'd0, 64'd5, 1'b0, 10};
    vecs[5] = '{64'd0, 64'd5, 64'd0, 64'd0, 1'b0, 0};
    vecs[6] = '{64'h8000_0000_0000_0000, 64'd3, 64'h2AAA_AAAA_AAAA_AAAA, 64'd2, 1'b0, 0};
    vecs[7] = '{64'd77, 64'd77, 64'd1, 64'd0, 1'b0, 2};

    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_quotient", bus.quotient, 64'd0);
    check("rst_remainder", bus.remainder, 64'd0);
    check("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
             vecs[i].dbz, vecs[i].stall);

    // Flush 20 cycles into BUSY: idle next cycle, killed op never reports.
    start_and_run(20);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    expect_no_valid("flush_no_valid", 80);

    // Operands presented together with flush are dropped.
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.dividend = 64'd9;
    bus.divisor  = 64'd3;
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_blocks_accept", 64'(bus.in_ready), 64'd1);
    expect_no_valid("flush_accept_no_valid", 70);

    // Asynchronous reset mid-operation: idle before any clock edge.
    start_and_run(20);
    #2 rst = 1'b1;
    #1 check("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    expect_no_valid("rst_no_valid", 80);

    run_op("after_kill", 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 7) == 0) a = a >> $urandom_range(0, 63);
      model(a, b, eq, er, ed);
      run_op($sformatf("rnd%0d", n), a, b, eq, er, ed, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unsigned_64.md
# div_unsigned_64

Iterative 64-bit unsigned restoring divider, one quotient bit per clock. Sits between the operand-side two's-complement stage, which supplies operand magnitudes, and the result-side two's-complement stage, which re-applies signs to quotient and remainder. Operands enter and results leave through valid/ready handshakes. A flush input kills an in-flight operation on pipeline redirect.

## Interface
- `XLEN`, 64: operand and result width. Only 64 is supported.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `flush`  in  1: synchronous kill; returns the block to IDLE.
- `in_valid`  in  1: operands valid.
- `in_ready`  out  1: block can accept operands.
- `dividend`  in  64: unsigned dividend magnitude.
- `divisor`  in  64: unsigned divisor magnitude.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts the result.
- `quotient`  out  64: unsigned quotient.
- `remainder`  out  64: unsigned remainder.
- `div_by_zero`  out  1: result came from a zero divisor.

## Operation
- States: IDLE, BUSY, DONE. Encoded in a 2-bit register. The fourth encoding goes to IDLE.
- `in_ready` = (state == IDLE). `out_valid` = (state == DONE). Both are decoded directly from state.
- Accept means `in_valid & in_ready` at an edge.
  - Latch the divisor.
  - Load the quotient/shift register with the dividend.
  - Clear the 65-bit partial remainder R.
  - Set the 6-bit iteration counter to 63.
- Accept with divisor == 0 goes straight to DONE with:
  - quotient = 64'hFFFF_FFFF_FFFF_FFFF
  - remainder = dividend
  - div_by_zero = 1
- Accept with a nonzero divisor goes to BUSY with div_by_zero = 0.
- BUSY iteration, one per edge:
  - R' = {R[63:0], Q[63]}.
  - T = R' − {1'b0, divisor}, a 65-bit subtraction.
  - If T[64] == 0: R = T and Q = {Q[62:0], 1}. Otherwise: R = R' and Q = {Q[62:0], 0}.
  - Decrement the counter.
  - The iteration performed while counter == 0 is the last one; on that edge the state goes to DONE.
- Result outputs:
  - `quotient` = Q and `remainder` = R[63:0]. Both are held stable throughout DONE.
  - In DONE, R[64] is always 0.
- DONE with `out_ready` = 1: go to IDLE on that edge.
  - No operand accept on the same edge, because `in_ready` is 0 in DONE.
- `flush` = 1 at an edge forces IDLE from any state. It takes priority over accept, iteration and result handoff.
  - An operand presented in the same cycle as `flush` is not accepted.
- `in_valid` during BUSY or DONE is ignored. Operands need not be held after accept.

## Timing
- Reset values:
  - state = IDLE, so `in_ready` = 1 and `out_valid` = 0.
  - `quotient` = 0, `remainder` = 0, `div_by_zero` = 0.
  - Counter = 0, R = 0, latched divisor = 0.
- Latency (accept edge = edge 0):
  - Nonzero divisor: the 64 iterations occur on edges 1..64, and `out_valid` rises after edge 64.
  - Zero divisor: `out_valid` rises after edge 0.
- Throughput: minimum 66 cycles between accepts for nonzero divisors, 2 cycles for zero divisors. The IDLE cycle after handoff is mandatory.
- Backpressure: DONE is held indefinitely while `out_ready` = 0. Outputs do not change during the wait.
- Reset mid-operation: the block returns to IDLE immediately (asynchronous) and the partial result is discarded.
- Flush during BUSY: IDLE after that edge. `out_valid` is never asserted for the killed operation.
- Result-register contents after a flush or handoff are don't-care; they are only meaningful while `out_valid` = 1.
- Dividend < divisor: quotient = 0, remainder = dividend, with the normal 64-iteration latency. There is no early termination.

## Test plan
- 100 / 7 with `out_ready` = 1:
  - quotient = 14, remainder = 2, div_by_zero = 0.
  - `out_valid` high exactly 64 cycles after accept, for one cycle.
  - `in_ready` high again in the following cycle.
- 64'hFFFF_FFFF_FFFF_FFFF / 1: quotient = all ones, remainder = 0.
- 64'hFFFF_FFFF_FFFF_FFFF / 64'h8000_0000_0000_0000: quotient = 1, remainder = 64'h7FFF_FFFF_FFFF_FFFF.
- 12345 / 0:
  - `out_valid` the cycle after accept.
  - quotient = all ones, remainder = 12345, div_by_zero = 1.
- Backpressure on 5 / 9:
  - Hold `out_ready` = 0 for 10 cycles after `out_valid`.
  - Outputs remain quotient = 0, remainder = 5, `in_ready` = 0.
  - Raise `out_ready`: `out_valid` drops the next cycle.
- Mid-operation kill:
  - Assert `flush` 20 cycles into BUSY: `in_ready` = 1 the next cycle and no `out_valid` follows.
  - Repeat with `rst`: `in_ready` = 1 without waiting for a clock edge.
  - A subsequent 100 / 7 still gives 14 remainder 2.
